// File: rtl/dmem_waitstate_if.sv
// Request/response bundle between the MEM stage and the wait-state data memory.
// The master drives the request; the slave returns the busy/done handshake, read data and error flags.
interface dmem_waitstate_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  ren;
  logic                  wen;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W/8-1:0]   be;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     dout;
  logic                  err_both;
  logic                  err_oob;

  modport master (
    output ren, wen, addr, din, be,
    input  busy, done, dout, err_both, err_oob
  );

  modport slave (
    input  ren, wen, addr, din, be,
    output busy, done, dout, err_both, err_oob
  );
endinterface

// File: rtl/dmem_waitstate.sv
// Word-addressed data memory with a fixed number of wait states, byte-enabled writes,
// a busy/done handshake and sticky error flags.
module dmem_waitstate #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DEPTH_LOG2 = 10,
  parameter int unsigned       LATENCY    = 2,
  parameter logic [ADDR_W-1:0] NULL_ADDR  = ADDR_W'(32'h3FFFFFFF)
) (
  input logic             clock,
  input logic             reset,
  dmem_waitstate_if.slave bus
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic [NBYTES-1:0]   be_q;
  logic [DATA_W-1:0]   dout_q;
  logic                err_both_q;
  logic                err_oob_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                cap_en;
  logic                both_req;
  logic                acc_fire;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_din;
  logic [NBYTES-1:0]   acc_be;
  logic                acc_null;
  logic                acc_oob;
  logic                acc_hit;
  logic [DEPTH_LOG2-1:0] acc_idx;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_en   = 1'b0;
    both_req = 1'b0;
    acc_fire = 1'b0;
    acc_we   = we_q;
    acc_addr = addr_q;
    acc_din  = din_q;
    acc_be   = be_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ren && bus.wen) begin
          both_req = 1'b1;
        end else if (bus.ren || bus.wen) begin
          cap_en = 1'b1;
          if (LATENCY == 0) begin
            // Zero wait states: the access happens at the accept edge from live inputs.
            acc_fire = 1'b1;
            acc_we   = bus.wen;
            acc_addr = bus.addr;
            acc_din  = bus.din;
            acc_be   = bus.be;
            state_d  = StResp;
          end else begin
            cnt_d   = 4'(LATENCY);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc_fire = 1'b1;
          state_d  = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    acc_idx  = acc_addr[DEPTH_LOG2-1:0];
    acc_null = (acc_addr == NULL_ADDR);
    acc_oob  = (|acc_addr[ADDR_W-1:DEPTH_LOG2]) && !acc_null;
    acc_hit  = !acc_oob && !acc_null;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      be_q       <= '0;
      dout_q     <= '0;
      err_both_q <= 1'b0;
      err_oob_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_en) begin
        we_q   <= bus.wen;
        addr_q <= bus.addr;
        din_q  <= bus.din;
        be_q   <= bus.be;
      end
      if (both_req) begin
        err_both_q <= 1'b1;
      end
      if (acc_fire && acc_oob) begin
        err_oob_q <= 1'b1;
      end
      if (acc_fire && !acc_we) begin
        dout_q <= acc_hit ? mem[acc_idx] : '0;
      end
    end
  end

  // Array is deliberately not reset; an aborted access never reaches acc_fire.
  always_ff @(posedge clock) begin
    if (acc_fire && acc_we && acc_hit) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_din[8*i +: 8];
        end
      end
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StResp);
  assign bus.dout     = dout_q;
  assign bus.err_both = err_both_q;
  assign bus.err_oob  = err_oob_q;

endmodule
